// File: rtl/jk_counter_reg.sv
// rtl/jk_counter_reg.sv - WIDTH-bit JK register bank with modulo up/down count and parallel load
module jk_counter_reg #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] notq,
    output logic             tc
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Top of the count range; for MODULUS = 2^WIDTH this is all-ones, so the
    // wrap coincides with natural overflow of the WIDTH-bit adder.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;

    logic [WIDTH-1:0] jk_next;
    logic             at_top;
    logic             at_zero;

    // Per-bit JK characteristic equation (Q+ = J & ~Q | ~K & Q) and wrap detection.
    always_comb begin
        jk_next = (j & ~q_q) | (~k & q_q);
        // Out-of-range values (above MAX_VAL) also wrap to zero when counting up.
        at_top  = (q_q >= MAX_VAL);
        at_zero = (q_q == '0);
    end

    // Next-state selection; disabled cycles hold q and drop the terminal-count pulse.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_JK: begin
                    q_d = jk_next;
                end
                MODE_UP: begin
                    if (at_top) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    // An out-of-range value simply decrements back into range.
                    if (at_zero) begin
                        q_d  = MAX_VAL;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q - ONE;
                    end
                end
                MODE_LOAD: begin
                    q_d = load_val;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    // State register; reset takes priority over enable and mode.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_q  <= RST_VAL;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    // Outputs: q and tc straight from flops, notq is a zero-latency complement.
    always_comb begin
        q    = q_q;
        notq = ~q_q;
        tc   = tc_q;
    end

endmodule

// File: tb/tb_jk_counter_reg.sv
// tb/tb_jk_counter_reg.sv - table-driven checks of jk_counter_reg (mod-10, plus RESET_VAL=5 instance)
module tb_jk_counter_reg;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] load_val;
    logic [3:0] q_a, notq_a, q_b, notq_b;
    logic       tc_a, tc_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    jk_counter_reg #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode),
        .j(j), .k(k), .load_val(load_val),
        .q(q_a), .notq(notq_a), .tc(tc_a)
    );

    jk_counter_reg #(.WIDTH(4), .MODULUS(10), .RESET_VAL(5)) dut_b (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode),
        .j(j), .k(k), .load_val(load_val),
        .q(q_b), .notq(notq_b), .tc(tc_b)
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] ld;
        logic [3:0] exp_q;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] ld,
                       input logic [3:0] eq, input logic etc);
        vec_t v;
        v.name = name; v.rst_n = r; v.en = e; v.mode = m;
        v.j = jj; v.k = kk; v.ld = ld; v.exp_q = eq; v.exp_tc = etc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_edge(input logic r, input logic e, input logic [1:0] m,
                              input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] ld);
        @(negedge clock);
        reset_n = r; en = e; mode = m; j = jj; k = kk; load_val = ld;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0; load_val = '0;

        // reset and hold
        add("reset1", 0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 4'd0, 0);
        add("reset2", 0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 4'd0, 0);
        for (int i = 0; i < 3; i++) add("hold", 1, 0, 2'b01, 4'hF, 4'h0, 4'hF, 4'd0, 0);
        // up-count wrap 1..9,0,1,2
        for (int i = 1; i <= 9; i++) add("up", 1, 1, 2'b01, 4'h0, 4'h0, 4'h0, 4'(i), 0);
        add("up_wrap", 1, 1, 2'b01, 4'h0, 4'h0, 4'h0, 4'd0, 1);
        add("up_after", 1, 1, 2'b01, 4'h0, 4'h0, 4'h0, 4'd1, 0);
        add("up_after", 1, 1, 2'b01, 4'h0, 4'h0, 4'h0, 4'd2, 0);
        // down-count wrap
        add("load1", 1, 1, 2'b11, 4'h0, 4'h0, 4'd1, 4'd1, 0);
        add("down", 1, 1, 2'b10, 4'h0, 4'h0, 4'h0, 4'd0, 0);
        add("down_wrap", 1, 1, 2'b10, 4'h0, 4'h0, 4'h0, 4'd9, 1);
        add("down", 1, 1, 2'b10, 4'h0, 4'h0, 4'h0, 4'd8, 0);
        // JK mode: hold/set/toggle/clear per bit
        add("load_a", 1, 1, 2'b11, 4'h0, 4'h0, 4'b1010, 4'b1010, 0);
        add("jk1", 1, 1, 2'b00, 4'b0110, 4'b0011, 4'h0, 4'b1100, 0);
        add("jk2", 1, 1, 2'b00, 4'b0110, 4'b0011, 4'h0, 4'b1110, 0);
        // out-of-range recovery
        add("load13", 1, 1, 2'b11, 4'h0, 4'h0, 4'd13, 4'd13, 0);
        add("oor_up", 1, 1, 2'b01, 4'h0, 4'h0, 4'h0, 4'd0, 1);
        add("load13b", 1, 1, 2'b11, 4'h0, 4'h0, 4'd13, 4'd13, 0);
        for (int i = 12; i >= 9; i--) add("oor_down", 1, 1, 2'b10, 4'h0, 4'h0, 4'h0, 4'(i), 0);
        // enable low right after a wrap clears tc and holds q
        add("load9", 1, 1, 2'b11, 4'h0, 4'h0, 4'd9, 4'd9, 0);
        add("wrap9", 1, 1, 2'b01, 4'h0, 4'h0, 4'h0, 4'd0, 1);
        add("en_off", 1, 0, 2'b11, 4'hF, 4'h0, 4'd7, 4'd0, 0);
        // reset priority over a load
        add("load4", 1, 1, 2'b11, 4'h0, 4'h0, 4'd4, 4'd4, 0);
        add("rst_prio", 0, 1, 2'b11, 4'h0, 4'h0, 4'd7, 4'd0, 0);

        foreach (vecs[i]) begin
            drive_edge(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].ld);
            check({vecs[i].name, ".q"}, q_a, vecs[i].exp_q);
            check({vecs[i].name, ".notq"}, notq_a, ~vecs[i].exp_q);
            check({vecs[i].name, ".tc"}, {3'b000, tc_a}, {3'b000, vecs[i].exp_tc});
        end

        // reset mid-count with RESET_VAL=5
        drive_edge(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("rv5.reset.q", q_b, 4'd5);
        drive_edge(1, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("rv5.up6.q", q_b, 4'd6);
        drive_edge(1, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("rv5.up7.q", q_b, 4'd7);
        drive_edge(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("rv5.mid_reset.q", q_b, 4'd5);
        check("rv5.mid_reset.tc", {3'b000, tc_b}, 4'd0);
        check("rv5.mid_reset.notq", notq_b, 4'hA);
        drive_edge(1, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("rv5.resume.q", q_b, 4'd6);
        check("rv5.resume.tc", {3'b000, tc_b}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_counter_reg.md
Name: jk_counter_reg

Overview:
- Parametrised WIDTH-bit register built from JK-cell semantics. It generalises the single JK flip-flop to a bank.
- Four selectable modes: per-bit JK, modulo up-count, modulo down-count, and parallel load.
- A registered terminal-count pulse is provided for cascading.
- Used wherever the design needs a small state register or a mod-N counter with JK-style bit control.

Parameters:
- WIDTH, 4: register width in bits (1..16).
- MODULUS, 16: count modulus; count range is 0..MODULUS-1 (2..2^WIDTH).
- RESET_VAL, 0: value loaded into q on reset (must be < 2^WIDTH).

Ports:
- clock  input  1  rising-edge clock, the only clock.
- reset_n  input  1  synchronous active-low reset, sampled on rising clock edge.
- en  input  1  update enable; 0 = hold.
- mode  input  2  00 JK, 01 count up, 10 count down, 11 load.
- j  input  WIDTH  per-bit J inputs (mode 00 only).
- k  input  WIDTH  per-bit K inputs (mode 00 only).
- load_val  input  WIDTH  parallel load data (mode 11 only).
- q  output  WIDTH  register state.
- notq  output  WIDTH  bitwise complement of q, always ~q (combinational).
- tc  output  1  registered terminal-count pulse.

Behaviour:
- Clock and reset:
  - All state updates on the rising edge of clock.
  - Reset is synchronous and active-low: reset_n=0 at an edge forces q=RESET_VAL and tc=0.
  - Reset has priority over en and mode.
  - Reset deasserted mid-count: counting resumes from RESET_VAL on the first edge with reset_n=1 and en=1.
- Enable:
  - en=0 at an edge: q holds, tc<=0.
  - j, k, load_val and mode are ignored.
- mode 00 (JK): per bit i, next q[i] is:
  - j=0,k=0: hold.
  - j=0,k=1: 0.
  - j=1,k=0: 1.
  - j=1,k=1: ~q[i].
  - The result is not constrained by MODULUS.
  - tc<=0.
- mode 01 (up):
  - If q >= MODULUS-1: q<=0 and tc<=1 (wrap).
  - Otherwise: q<=q+1 and tc<=0.
- mode 10 (down):
  - If q == 0: q<=MODULUS-1 and tc<=1 (wrap).
  - Otherwise: q<=q-1 and tc<=0.
  - An out-of-range q (>= MODULUS, reachable via JK or load) decrements normally until it re-enters range.
- mode 11 (load):
  - q<=load_val, stored unmodified even if >= MODULUS.
  - tc<=0.
- tc timing:
  - tc is high for exactly the one cycle following a wrapping edge.
  - Back-to-back wraps are possible only when MODULUS... not applicable (minimum 2), so tc is never high on two consecutive cycles except when MODULUS=1 (disallowed).
- Latency:
  - q reflects inputs one edge after sampling.
  - notq follows q with zero latency.
- Arithmetic:
  - All count arithmetic is WIDTH bits, unsigned.
  - When MODULUS=2^WIDTH, the wrap condition coincides with natural overflow.
- No X propagation: q and tc are defined from the first reset edge onward.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0 unless noted):
- Reset and hold:
  - Stimulus: reset_n=0 for 2 edges with en=1, mode=01.
  - Response: q=0, notq=4'hF, tc=0. Then en=0 for 3 edges → q stays 0, tc=0.
- Up-count wrap:
  - Stimulus: en=1, mode=01 for 12 edges from 0.
  - Response: q runs 1..9, 0, 1, 2. tc=1 only in the cycle after the 9→0 edge.
- Down-count wrap:
  - Stimulus: load 4'd1 (mode=11), then mode=10 for 3 edges.
  - Response: q=0, then 9 with tc=1 for one cycle, then 8.
- JK mode:
  - Stimulus: q=4'b1010; j=4'b0110, k=4'b0011.
  - Response: per-bit results are bit3 hold=1, bit2 set=1, bit1 toggle=0, bit0 clear=0, so q=4'b1100. A second identical edge gives q=4'b1110.
- Out-of-range recovery:
  - Stimulus: load 4'd13, then mode=01 for 1 edge.
  - Response: q=0, tc=1.
  - Then reload 13 and apply mode=10 for 4 edges → q=12, 11, 10, 9 with tc=0 throughout.
- Reset mid-count:
  - Stimulus (RESET_VAL=5): count up to 7, assert reset_n=0 for 1 edge, release.
  - Response: q=5, tc=0, then q=6 on the next edge with en=1, mode=01.
